// File: rtl/priority_request_scheduler.sv
// priority_request_scheduler: sticky 12-line request latch feeding a priority encoder,
// offering its code on a valid/ready handshake and retiring each serviced request.
module priority_request_scheduler #(
  parameter int GAP_CYCLES = 2,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [11:0]      i_req,
  input  logic             i_clr_all,
  output logic [11:0]      o_pending,
  input  logic [3:0]       i_code,
  output logic             o_valid,
  output logic [3:0]       o_code,
  input  logic             i_ready,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_serviced_cnt,
  output logic             o_err
);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, OFFER, GAP} state_e;

  state_e           state_q, state_d;
  logic [11:0]      pending_q, pending_d;
  logic [3:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             hs;
  logic [11:0]      clr_mask;

  assign hs = valid_q & i_ready;
  // set wins over clear: i_req is OR-ed in after the serviced bit is masked off
  assign clr_mask = hs ? (12'd1 << (code_q - 4'd1)) : 12'd0;

  always_comb begin
    state_d = state_q;
    pending_d = (pending_q & ~clr_mask) | i_req;
    code_d = code_q;
    valid_d = valid_q;
    cnt_d = cnt_q;
    err_d = err_q;
    gap_d = gap_q;
    if (i_clr_all) begin
      pending_d = '0;
      valid_d = 1'b0;
      state_d = IDLE;
      gap_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_code >= 4'd1 && i_code <= 4'd12) begin
            code_d = i_code;
            valid_d = 1'b1;
            state_d = OFFER;
          end else if (i_code > 4'd12) begin
            err_d = 1'b1;
          end
        end
        OFFER: begin
          if (hs) begin
            valid_d = 1'b0;
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
            gap_d = '0;
            state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
          end
        end
        GAP: begin
          state_d = (gap_q == GW'(GAP_CYCLES - 1)) ? IDLE : GAP;
          gap_d = (gap_q == GW'(GAP_CYCLES - 1)) ? '0 : gap_q + GW'(1);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      pending_q <= '0;
      code_q <= '0;
      valid_q <= 1'b0;
      cnt_q <= '0;
      err_q <= 1'b0;
      gap_q <= '0;
    end else begin
      state_q <= state_d;
      pending_q <= pending_d;
      code_q <= code_d;
      valid_q <= valid_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      gap_q <= gap_d;
    end
  end

  assign o_pending = pending_q;
  assign o_valid = valid_q;
  assign o_code = code_q;
  assign o_busy = (state_q != IDLE);
  assign o_serviced_cnt = cnt_q;
  assign o_err = err_q;
endmodule

// File: tb/tb_priority_request_scheduler.sv
// tb_priority_request_scheduler: directed bench with an encoder model, a grant
// scoreboard for the main instance, and a small-counter zero-gap second instance.
module tb_priority_request_scheduler;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] req = '0, pending;
  logic        clr_all = 1'b0, valid, ready = 1'b0, busy, err;
  logic [3:0]  code, ocode;
  logic [7:0]  cnt;
  logic        force_en = 1'b0;
  logic [3:0]  force_val = '0;
  logic [11:0] req2 = '0, pending2;
  logic        clr2 = 1'b0, valid2, ready2 = 1'b0, busy2, err2;
  logic [3:0]  code2, ocode2;
  logic [1:0]  cnt2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_hs = -1;
  bit spacing_on = 1'b0;
  logic [3:0] sb[$];

  always #5 clk = ~clk;

  function automatic logic [3:0] enc(input logic [11:0] p);
    enc = 4'd0;
    for (int i = 0; i < 12; i++) if (p[i]) enc = 4'(i + 1);
  endfunction

  assign code = force_en ? force_val : enc(pending);
  assign code2 = enc(pending2);

  priority_request_scheduler #(.GAP_CYCLES(2), .CNT_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_clr_all(clr_all),
    .o_pending(pending), .i_code(code), .o_valid(valid), .o_code(ocode),
    .i_ready(ready), .o_busy(busy), .o_serviced_cnt(cnt), .o_err(err)
  );

  priority_request_scheduler #(.GAP_CYCLES(0), .CNT_W(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req2), .i_clr_all(clr2),
    .o_pending(pending2), .i_code(code2), .o_valid(valid2), .o_code(ocode2),
    .i_ready(ready2), .o_busy(busy2), .o_serviced_cnt(cnt2), .o_err(err2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock: handshakes are scored at the falling edge, before the accepting edge
  task automatic tick();
    logic [3:0] e;
    @(negedge clk);
    if (valid && ready && !clr_all) begin
      if (sb.size() == 0) chk("unexpected_grant", {28'd0, ocode}, 32'd0);
      else begin
        e = sb.pop_front();
        chk("grant_code", {28'd0, ocode}, {28'd0, e});
      end
      if (spacing_on) begin
        if (last_hs >= 0) chk("grant_spacing", cyc - last_hs, 4);
        last_hs = cyc;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    if (sb.size() > 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    #3;
    chk("rst_pending", {20'd0, pending}, 0);
    chk("rst_valid", {31'd0, valid}, 0);
    chk("rst_code", {28'd0, ocode}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_cnt", {24'd0, cnt}, 0);
    chk("rst_err", {31'd0, err}, 0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;
    // single request: pending after 1 cycle, offer after 2
    req = 12'h010;
    tick();
    chk("t1_pending", {20'd0, pending}, 32'h010);
    chk("t1_valid_early", {31'd0, valid}, 0);
    req = '0;
    tick();
    chk("t1_valid", {31'd0, valid}, 1);
    chk("t1_code", {28'd0, ocode}, 5);
    chk("t1_busy", {31'd0, busy}, 1);
    sb.push_back(4'd5);
    ready = 1'b1;
    tick();
    chk("t1_pending_clr", {20'd0, pending}, 0);
    chk("t1_cnt", {24'd0, cnt}, 1);
    chk("t1_valid_drop", {31'd0, valid}, 0);
    chk("t1_busy_gap", {31'd0, busy}, 1);
    ready = 1'b0;
    tick();
    tick();
    chk("t1_idle", {31'd0, busy}, 0);
    // all twelve requests drain in descending order, 4 cycles apart
    req = 12'hFFF;
    for (int i = 12; i >= 1; i--) sb.push_back(4'(i));
    spacing_on = 1'b1;
    last_hs = -1;
    tick();
    req = '0;
    ready = 1'b1;
    drain(80);
    spacing_on = 1'b0;
    chk("t2_pending", {20'd0, pending}, 0);
    chk("t2_cnt", {24'd0, cnt}, 13);
    ready = 1'b0;
    tick();
    tick();
    chk("t2_idle", {31'd0, busy}, 0);
    // no preemption: code 3 held while bit 11 arrives, then 12
    req = 12'h004;
    sb.push_back(4'd3);
    sb.push_back(4'd12);
    tick();
    req = '0;
    tick();
    req = 12'h800;
    tick();
    req = '0;
    tick();
    tick();
    chk("t3_code_held", {28'd0, ocode}, 3);
    chk("t3_valid_held", {31'd0, valid}, 1);
    chk("t3_pending", {20'd0, pending}, 32'h804);
    ready = 1'b1;
    drain(30);
    ready = 1'b0;
    tick();
    tick();
    chk("t3_pending_end", {20'd0, pending}, 0);
    chk("t3_idle", {31'd0, busy}, 0);
    // request on the bit being serviced survives the clear
    req = 12'h008;
    sb.push_back(4'd4);
    sb.push_back(4'd4);
    tick();
    req = '0;
    tick();
    ready = 1'b1;
    req = 12'h008;
    tick();
    req = '0;
    chk("t4_set_wins", {20'd0, pending}, 32'h008);
    drain(30);
    ready = 1'b0;
    tick();
    tick();
    chk("t4_pending_end", {20'd0, pending}, 0);
    chk("t4_cnt", {24'd0, cnt}, 17);
    // flush mid-offer with ready high: nothing counted, same-cycle request dropped
    req = 12'h002;
    tick();
    req = '0;
    tick();
    chk("t5_offer", {31'd0, valid}, 1);
    clr_all = 1'b1;
    ready = 1'b1;
    req = 12'h001;
    tick();
    clr_all = 1'b0;
    ready = 1'b0;
    req = '0;
    chk("t5_valid", {31'd0, valid}, 0);
    chk("t5_pending", {20'd0, pending}, 0);
    chk("t5_cnt", {24'd0, cnt}, 17);
    chk("t5_busy", {31'd0, busy}, 0);
    force_en = 1'b1;
    force_val = 4'd14;
    tick();
    chk("t5_err", {31'd0, err}, 1);
    chk("t5_no_offer", {31'd0, valid}, 0);
    tick();
    chk("t5_still_idle", {31'd0, busy}, 0);
    force_en = 1'b0;
    // asynchronous reset between edges during an offer
    req = 12'h010;
    tick();
    req = '0;
    tick();
    chk("t6_offer", {31'd0, valid}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", {31'd0, valid}, 0);
    chk("t6_code", {28'd0, ocode}, 0);
    chk("t6_pending", {20'd0, pending}, 0);
    chk("t6_cnt", {24'd0, cnt}, 0);
    chk("t6_err", {31'd0, err}, 0);
    chk("t6_busy", {31'd0, busy}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // 2-bit counter, zero gap: five grants saturate at 3
    req2 = 12'h01F;
    ready2 = 1'b1;
    tick();
    req2 = '0;
    repeat (20) tick();
    chk("t7_cnt_sat", {30'd0, cnt2}, 3);
    chk("t7_pending", {20'd0, pending2}, 0);
    chk("t7_valid", {31'd0, valid2}, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/priority_request_scheduler.md
Name: priority_request_scheduler

Overview:
- Upstream/downstream companion to the 12-to-4 dual priority encoder.
- Latches 12 request lines into a sticky pending vector and drives that vector into the encoder.
- Takes the encoder's 4-bit code back (1..12 = highest pending bit index+1, 0 = none).
- Offers the code on a valid/ready handshake and clears the pending bit once it is serviced, so the encoder then presents the next-highest request.

Parameters:
- GAP_CYCLES, 2, idle cycles inserted after each accepted grant before the next offer (0 allowed)
- CNT_W, 8, width of the serviced-grant counter

Ports:
- i_clk  input  1  system clock, rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_req  input  12  request lines; any cycle high sets the matching pending bit
- i_clr_all  input  1  synchronous flush of all pending requests and any offer in flight
- o_pending  output  12  registered pending vector, wired to the encoder's i_num
- i_code  input  4  encoder o_result (combinational from o_pending)
- o_valid  output  1  grant offer valid
- o_code  output  4  granted code (1..12), stable while o_valid=1
- i_ready  input  1  consumer accepts the offer when o_valid & i_ready
- o_busy  output  1  high in any state other than IDLE
- o_serviced_cnt  output  CNT_W  accepted grants, saturating
- o_err  output  1  sticky: an illegal code (13..15) was seen in IDLE

Behaviour:
- Reset (i_rst_n=0, asynchronous, takes effect immediately even mid-offer):
  - o_pending=0, o_valid=0, o_code=0, o_busy=0, o_serviced_cnt=0, o_err=0, state=IDLE, gap counter=0.
- Pending register update (every clock):
  - pending_next = (pending & ~clear_mask) | i_req.
  - clear_mask is one-hot at bit o_code-1 only on the handshake cycle.
  - Set wins over clear: a request on the bit being cleared in the same cycle leaves it pending.
- States: IDLE, OFFER, GAP.
  - IDLE:
    - i_code in 1..12 -> register o_code=i_code, o_valid=1 next cycle, go to OFFER.
    - i_code=0 -> stay in IDLE.
    - i_code in 13..15 -> stay in IDLE and set o_err.
  - OFFER:
    - o_valid=1 and o_code held stable until the handshake; no preemption by a higher-priority request arriving meanwhile.
    - On o_valid & i_ready: clear the pending bit, increment o_serviced_cnt (saturate at 2^CNT_W-1), set o_valid=0 next cycle.
    - Then go to GAP if GAP_CYCLES>0, else to IDLE.
  - GAP:
    - Count GAP_CYCLES clocks with o_valid=0, then go to IDLE.
    - i_code is ignored in GAP.
- Latency:
  - i_req pulse at edge t -> pending set after edge t -> o_valid=1 after edge t+1 (2 cycles), given IDLE.
  - Back-to-back grants are spaced by 1 (handshake) + GAP_CYCLES + 1 (IDLE capture) cycles minimum.
- i_clr_all (synchronous, highest priority after reset):
  - Next cycle o_pending=0, o_valid=0, state=IDLE, gap counter cleared.
  - No count increment, even if i_ready was high the same cycle.
  - i_req in the same cycle is discarded.
- Other boundaries:
  - All 12 bits pending -> codes emitted in order 12,11,...,1; o_pending reaches 0 after 12 handshakes.
  - Counter saturates and does not wrap.
  - o_err is cleared only by reset.
  - o_busy is combinational from the state.

Test Plan:
- Reset then single pulse i_req=12'h010 -> o_pending=12'h010 after 1 cycle; o_valid=1, o_code=4'd5 after 2 cycles; i_ready=1 -> o_pending=0, o_serviced_cnt=1.
- i_req=12'hFFF for one cycle, i_ready tied 1, GAP_CYCLES=2 -> o_code sequence 12..1, each offer 4 cycles apart, final o_serviced_cnt=12, o_pending=0.
- Offer code 3 with i_ready=0; assert i_req bit 11 -> o_code stays 3 until ready; next offer is 12.
- Handshake on code 4 with i_req[3]=1 in the same cycle -> o_pending[3] stays 1; code 4 is offered again after the gap.
- i_clr_all during OFFER with i_ready=1 -> o_valid=0, o_pending=0, count unchanged, state IDLE; then force i_code=4'd14 in IDLE -> o_err=1, no offer.
- Deassert i_rst_n mid-OFFER between clock edges -> all outputs 0 immediately; with CNT_W=2, five grants -> o_serviced_cnt=3.
